life_display_scan: RTL and testbench

Reads the Game-of-Life cell array and drives a row-multiplexed LED matrix. It snapshots the array once per generation and scans the snapshot row by row. After a programmable number of frames it issues a one-cycle step pulse that advances the cell array. It also reports population, extinction and still-life status to the top level.

---
 rtl/life_pkg.sv | 32 +++
 rtl/row_popcount.sv | 15 +
 rtl/life_display_scan.sv | 137 +++++++++++++
 tb/tb_life_display_scan.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life LED matrix scanner.
package life_pkg;

  localparam int unsigned DEF_ROWS  = 8;
  localparam int unsigned DEF_COLS  = 8;
  localparam int unsigned MAX_DIM   = 16;
  localparam int unsigned GRID_BITS = MAX_DIM * MAX_DIM;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    SCAN,
    STEP
  } state_t;

  // Row r of a packed grid occupies bits r*cols .. r*cols+cols-1; bits above cols are zero.
  function automatic logic [MAX_DIM-1:0] get_row(input logic [GRID_BITS-1:0] cells,
                                                 input int unsigned cols,
                                                 input int unsigned row);
    logic [MAX_DIM-1:0] bits;
    logic [7:0]         idx;
    bits = '0;
    for (int unsigned c = 0; c < MAX_DIM; c++) begin
      if (c < cols) begin
        idx          = 8'(row * cols + c);
        bits[4'(c)] = cells[idx];
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/row_popcount.sv
// Combinational live-cell count of one grid row.
module row_popcount #(
  parameter int unsigned COLS = 8
) (
  input  logic [COLS-1:0]            bits,
  output logic [$clog2(COLS+1)-1:0]  count
);

  localparam int unsigned CW = $clog2(COLS + 1);

  always_comb begin
    count = CW'($countones(bits));
  end

endmodule

// File: rtl/life_display_scan.sv
// Snapshots the life grid each generation, row-scans it onto an LED matrix,
// pulses gen_step after FRAMES_PER_GEN frames and reports population/extinct/still.
module life_display_scan
  import life_pkg::*;
#(
  parameter int unsigned ROWS           = DEF_ROWS,
  parameter int unsigned COLS           = DEF_COLS,
  parameter int unsigned DWELL          = 4,
  parameter int unsigned FRAMES_PER_GEN = 2
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic [ROWS*COLS-1:0]               grid,
  output logic [ROWS-1:0]                    row_sel,
  output logic [COLS-1:0]                    col_data,
  output logic                               gen_step,
  output logic [$clog2(ROWS*COLS+1)-1:0]     population,
  output logic                               extinct,
  output logic                               still
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned PW    = $clog2(CELLS + 1);
  localparam int unsigned CW    = $clog2(COLS + 1);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned FW    = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  state_t            state, state_next;
  logic [RW-1:0]     row_idx;
  logic [DW-1:0]     dwell_cnt;
  logic [FW-1:0]     frame_cnt;
  logic [PW-1:0]     acc, acc_sum;
  logic [CELLS-1:0]  snapshot;
  logic              have_prev;
  logic [COLS-1:0]   cur_row;
  logic [CW-1:0]     row_count;
  logic              row_end, frame_end, gen_end, add_now;

  assign cur_row = COLS'(get_row(GRID_BITS'(snapshot), COLS, 32'(row_idx)));

  row_popcount #(.COLS(COLS)) u_row_popcount (
    .bits  (cur_row),
    .count (row_count)
  );

  assign row_end   = (dwell_cnt == DW'(DWELL - 1));
  assign frame_end = row_end && (row_idx == RW'(ROWS - 1));
  assign gen_end   = frame_end && (frame_cnt == FW'(FRAMES_PER_GEN - 1));
  assign add_now   = (dwell_cnt == '0) && (frame_cnt == '0);
  // acc_sum already includes the row on screen, so committing it at frame end is a full count for any DWELL.
  assign acc_sum   = acc + (add_now ? PW'(row_count) : PW'(0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = LATCH;
      LATCH:   state_next = enable ? SCAN : IDLE;
      SCAN: begin
        if (!enable)      state_next = IDLE;
        else if (gen_end) state_next = STEP;
      end
      STEP:    state_next = enable ? LATCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    row_sel  = '0;
    col_data = '0;
    gen_step = (state == STEP);
    if (state == SCAN) begin
      row_sel  = ROWS'(1) << row_idx;
      col_data = cur_row;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_idx    <= '0;
      dwell_cnt  <= '0;
      frame_cnt  <= '0;
      acc        <= '0;
      snapshot   <= '0;
      have_prev  <= 1'b0;
      population <= '0;
      extinct    <= 1'b0;
      still      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          row_idx   <= '0;
          dwell_cnt <= '0;
          frame_cnt <= '0;
          acc       <= '0;
        end
        LATCH: begin
          if (enable) begin
            snapshot  <= grid;
            acc       <= '0;
            extinct   <= (grid == '0);
            still     <= have_prev && (grid == snapshot);
            have_prev <= 1'b1;
            row_idx   <= '0;
            dwell_cnt <= '0;
            frame_cnt <= '0;
          end
        end
        SCAN: begin
          if (enable) begin
            acc <= acc_sum;
            if (frame_end && (frame_cnt == '0)) population <= acc_sum;
            if (row_end) begin
              dwell_cnt <= '0;
              if (row_idx == RW'(ROWS - 1)) begin
                row_idx   <= '0;
                frame_cnt <= frame_cnt + 1'b1;
              end else begin
                row_idx <= row_idx + 1'b1;
              end
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_display_scan.sv
// Bench for life_display_scan: generation-position model checked every cycle, plus directed literal checks.
module tb_life_display_scan;

  localparam int unsigned R         = 8;
  localparam int unsigned C         = 8;
  localparam int unsigned D         = 4;
  localparam int unsigned F         = 2;
  localparam int unsigned FRAME_LEN = R * D;
  localparam int unsigned SCAN_LEN  = F * R * D;

  localparam logic [63:0] BLINK_H = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
  localparam logic [63:0] BLINK_V = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
  localparam logic [63:0] BLOCK   = (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36);

  logic        clock = 1'b0;
  logic        reset_n, enable, en2;
  logic [63:0] grid;
  logic [15:0] grid2;

  logic [7:0]  row_sel, col_data;
  logic        gen_step, extinct, still;
  logic [6:0]  population;
  logic [3:0]  row_sel2, col_data2;
  logic        gen_step2, extinct2, still2;
  logic [4:0]  population2;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 0;

  // Model: position within a generation (0 = latch, 1..SCAN_LEN = scan, SCAN_LEN+1 = step).
  bit          m_run   = 0;
  int          m_t     = 0;
  logic [63:0] m_snap  = '0;
  int          m_pop   = 0;
  bit          m_ext   = 0;
  bit          m_still = 0;
  bit          m_have  = 0;

  always #5 clock = ~clock;

  life_display_scan #(
    .ROWS(8), .COLS(8), .DWELL(4), .FRAMES_PER_GEN(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .grid(grid),
    .row_sel(row_sel), .col_data(col_data), .gen_step(gen_step),
    .population(population), .extinct(extinct), .still(still)
  );

  life_display_scan #(
    .ROWS(4), .COLS(4), .DWELL(1), .FRAMES_PER_GEN(1)
  ) dut_small (
    .clock(clock), .reset_n(reset_n), .enable(en2), .grid(grid2),
    .row_sel(row_sel2), .col_data(col_data2), .gen_step(gen_step2),
    .population(population2), .extinct(extinct2), .still(still2)
  );

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_t = 0; m_snap = '0; m_pop = 0; m_ext = 0; m_still = 0; m_have = 0;
    end else if (!m_run) begin
      if (enable) begin m_run = 1; m_t = 0; end
    end else if (!enable) begin
      m_run = 0;
    end else if (m_t == 0) begin
      m_still = m_have && (grid == m_snap);
      m_ext   = (grid == '0);
      m_snap  = grid;
      m_have  = 1;
      m_t     = 1;
    end else if (m_t <= int'(SCAN_LEN)) begin
      if (m_t == int'(FRAME_LEN)) m_pop = $countones(m_snap);
      m_t++;
    end else begin
      m_t = 0;
    end
  end

  always @(negedge clock) begin
    logic [7:0] exp_rs, exp_cd;
    logic       exp_gs;
    int         r;
    if (checking) begin
      exp_rs = '0;
      exp_cd = '0;
      exp_gs = m_run && (m_t == int'(SCAN_LEN) + 1);
      if (m_run && m_t >= 1 && m_t <= int'(SCAN_LEN)) begin
        r      = ((m_t - 1) / int'(D)) % int'(R);
        exp_rs = 8'(1 << r);
        exp_cd = m_snap[r*C +: C];
      end
      vectors++;
      if (row_sel !== exp_rs || col_data !== exp_cd || gen_step !== exp_gs ||
          population !== 7'(m_pop) || extinct !== m_ext || still !== m_still) begin
        miscompares++;
        $display("FAIL model t=%0d: got rs=%h cd=%h gs=%b pop=%0d ext=%b st=%b, expected rs=%h cd=%h gs=%b pop=%0d ext=%b st=%b",
                 m_t, row_sel, col_data, gen_step, population, extinct, still,
                 exp_rs, exp_cd, exp_gs, m_pop, m_ext, m_still);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_step(input int limit);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (gen_step !== 1'b1 && n < limit);
    check("gen_step_within_budget", 32'(gen_step), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, first, pulses;
    reset_n = 1'b0; enable = 1'b0; en2 = 1'b0; grid = '0; grid2 = '0;
    repeat (3) @(negedge clock);
    check("reset_row_sel", 32'(row_sel), 0);
    check("reset_col_data", 32'(col_data), 0);
    check("reset_gen_step", 32'(gen_step), 0);
    check("reset_population", 32'(population), 0);
    check("reset_flags", {30'd0, extinct, still}, 0);
    check("reset_small_row_sel", 32'(row_sel2), 0);
    checking = 1;
    reset_n  = 1'b1;
    @(negedge clock);

    // Empty grid: row walk and generation period
    enable = 1'b1;
    n = 0; first = 0;
    while (first == 0 && n < 200) begin
      @(negedge clock);
      n++;
      if (n == 1)  check("latch_blank", 32'(row_sel), 0);
      if (n == 2)  check("row0_strobe", 32'(row_sel), 'h01);
      if (n == 5)  check("row0_last_dwell", 32'(row_sel), 'h01);
      if (n == 6)  check("row1_strobe", 32'(row_sel), 'h02);
      if (n == 30) check("row7_strobe", 32'(row_sel), 'h80);
      if (n == 34) check("frame1_row0", 32'(row_sel), 'h01);
      if (gen_step === 1'b1) first = n;
    end
    check("first_gen_step_cycle", first, 66);
    check("empty_extinct", 32'(extinct), 1);
    check("empty_population", 32'(population), 0);
    check("step_blank_cols", 32'(col_data), 0);

    // Blinker toggling on each step
    grid = BLINK_H;
    repeat (2) @(negedge clock);
    check("blink_h_still", 32'(still), 0);
    check("blink_h_extinct", 32'(extinct), 0);
    repeat (12) @(negedge clock);
    check("blink_row3_sel", 32'(row_sel), 'h08);
    check("blink_row3_cols", 32'(col_data), 'h1C);
    wait_step(100);
    check("blink_h_population", 32'(population), 3);
    grid = BLINK_V;
    repeat (2) @(negedge clock);
    check("blink_v_still", 32'(still), 0);
    repeat (8) @(negedge clock);
    check("blink_v_row2_sel", 32'(row_sel), 'h04);
    check("blink_v_row2_cols", 32'(col_data), 'h08);
    wait_step(100);
    check("blink_v_population", 32'(population), 3);
    grid = BLINK_H;
    repeat (2) @(negedge clock);
    check("blink_h2_still", 32'(still), 0);

    // Block held constant
    wait_step(100);
    grid = BLOCK;
    repeat (2) @(negedge clock);
    check("block_first_still", 32'(still), 0);
    wait_step(100);
    repeat (2) @(negedge clock);
    check("block_second_still", 32'(still), 1);
    wait_step(100);
    check("block_population", 32'(population), 4);

    // Drop enable mid-scan
    repeat (2) @(negedge clock);
    repeat (19) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("disable_blank_rows", 32'(row_sel), 0);
    check("disable_blank_cols", 32'(col_data), 0);
    pulses = 0;
    repeat (100) begin
      @(negedge clock);
      if (gen_step === 1'b1) pulses++;
    end
    check("no_step_while_disabled", pulses, 0);
    check("disabled_population_kept", 32'(population), 4);
    check("disabled_still_kept", 32'(still), 1);

    // Re-enable with a single live cell
    grid   = 64'd1;
    enable = 1'b1;
    @(negedge clock);
    check("reenable_latch_blank", 32'(row_sel), 0);
    @(negedge clock);
    check("reenable_row0", 32'(row_sel), 'h01);
    check("reenable_row0_cols", 32'(col_data), 'h01);
    check("reenable_still", 32'(still), 0);
    check("reenable_old_population", 32'(population), 4);
    repeat (31) @(negedge clock);
    check("population_before_frame0_end", 32'(population), 4);
    @(negedge clock);
    check("population_after_frame0_end", 32'(population), 1);

    // Asynchronous reset in row 5
    wait_step(100);
    repeat (2) @(negedge clock);
    repeat (21) @(negedge clock);
    check("row5_before_reset", 32'(row_sel), 'h20);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_rows", 32'(row_sel), 0);
    check("async_reset_cols", 32'(col_data), 0);
    check("async_reset_population", 32'(population), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("post_reset_row0", 32'(row_sel), 'h01);
    check("post_reset_still", 32'(still), 0);
    wait_step(100);
    check("post_reset_population", 32'(population), 1);
    repeat (2) @(negedge clock);
    check("post_reset_second_still", 32'(still), 1);
    enable = 1'b0;
    repeat (2) @(negedge clock);

    // Small instance: 4x4, DWELL=1, one frame per generation
    grid2 = 16'hFFFF;
    en2   = 1'b1;
    n = 0; first = 0;
    while (first == 0 && n < 50) begin
      @(negedge clock);
      n++;
      if (n == 2) check("small_row0", 32'(row_sel2), 'h1);
      if (n == 3) check("small_row1_cols", 32'(col_data2), 'hF);
      if (n == 5) check("small_row3", 32'(row_sel2), 'h8);
      if (gen_step2 === 1'b1) first = n;
    end
    check("small_first_step_cycle", first, 6);
    n = 0; first = 0;
    while (first == 0 && n < 50) begin
      @(negedge clock);
      n++;
      if (n == 1) check("small_step_one_cycle", 32'(gen_step2), 0);
      if (gen_step2 === 1'b1) first = n;
    end
    check("small_gen_period", first, 6);
    check("small_population", 32'(population2), 16);
    check("small_extinct", 32'(extinct2), 0);
    repeat (2) @(negedge clock);
    check("small_still", 32'(still2), 1);
    en2 = 1'b0;
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
